img_frame_loader: RTL and testbench
===================================

Name: img_frame_loader

Overview:
- Receive side of the image-frame interface that feeds each TrafficSignal instance's 3072-bit image input and its priority and emergency nibbles.
- Accepts a byte stream with a valid/ready handshake and assembles each frame into a 3072-bit word.
- Presents one complete frame, tagged with its target signal (Mid/L/R/T/D) and its priority/emergency values, to the downstream frame-distribution logic over a second valid/ready handshake.
- Replaces bulk file loading with a cycle-accurate serial load path.

Parameters:
- FRAME_BITS, 3072, payload width in bits; must be a multiple of BYTE_W.
- BYTE_W, 8, stream symbol width.
- N_SIG, 5, number of valid target IDs (0=Mid, 1=L, 2=R, 3=T, 4=D).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_valid  in  1  input byte valid.
- s_ready  out  1  loader can accept a byte.
- s_data  in  BYTE_W  input byte.
- frame_valid  out  1  assembled frame available.
- frame_ready  in  1  downstream accepts the frame.
- frame_data  out  FRAME_BITS  assembled image.
- frame_target  out  3  target signal ID.
- frame_prio  out  4  priority nibble.
- frame_emer  out  4  emergency nibble.
- hdr_err  out  1  one-cycle pulse when a bad header is dropped.

Behaviour:
- Reset (async assert, sync deassert use): state=IDLE, byte counter=0, frame_data=0, frame_target=0, frame_prio=0, frame_emer=0, frame_valid=0, hdr_err=0. s_ready=1 after reset.
- Byte transfer: a byte is taken when s_valid && s_ready at a rising edge.
- s_ready is 1 in IDLE, PAYLOAD and CTRL, and 0 in HOLD. It is registered-state derived; there is no combinational path from s_valid.
- Frame format, in order:
  - Header byte: [2:0]=target, [7:3] must be 0.
  - FRAME_BITS/BYTE_W = 384 payload bytes.
  - One control byte: [7:4]=prio, [3:0]=emer.
- IDLE:
  - Accepted header with target<N_SIG and [7:3]==0: latch target, clear counter, go to PAYLOAD.
  - Otherwise: drop the byte, pulse hdr_err for exactly one cycle (the cycle after acceptance), stay in IDLE.
- PAYLOAD:
  - Byte k (k=0..383) is written to frame_data[FRAME_BITS-1-8k -: 8]. The first byte received is the MSB byte, matching the %b text order of the frame files.
  - Counter increments per accepted byte. On accepting byte 383, go to CTRL. The counter is 9 bits and never wraps within a frame.
- CTRL: accepted byte latches prio and emer. Go to HOLD; frame_valid=1 from the next cycle.
- HOLD:
  - frame_valid stays 1 and all frame_* outputs stay stable until frame_valid && frame_ready.
  - On that edge: frame_valid=0 and state goes to IDLE.
  - The next header can therefore be accepted no earlier than one cycle after the frame handshake.
- Stall tolerance: gaps in s_valid at any point do not alter state or counter.
- frame_ready high outside HOLD has no effect.
- Latency: frame_valid rises 1 cycle after the control byte is accepted. With continuous input, minimum period is 386 accepted bytes plus 1 hold cycle per frame.
- frame_data is updated in place while a frame is loading. Downstream must sample it only while frame_valid=1.
- Reset mid-frame: the partial frame is discarded, all outputs return to reset values, and the next byte is treated as a header.

Decomposition:
- Shared package traffic_pkg holds:
  - SIG_MID=0, SIG_L=1, SIG_R=2, SIG_T=3, SIG_D=4, N_SIG.
  - FRAME_BITS and the derived FRAME_BYTES.
  - The loader_state_t enum {IDLE, PAYLOAD, CTRL, HOLD}.
- No sub-module; a single FSM plus counter is natural. A separate target demux (frame_router) belongs in the parent, not in this block.

Test Plan:
- Back-to-back frame, header 0x02, payload bytes i&0xFF, ctrl 0x48, frame_ready=1:
  - frame_valid rises exactly 1 cycle after the ctrl byte.
  - frame_target=2, frame_prio=4, frame_emer=8.
  - frame_data[3071:3064]=0x00 and frame_data[7:0]=0x7F (byte 383).
  - frame_valid is high for 1 cycle.
- Bad headers 0x05, then 0x0B, then valid 0x00:
  - Two hdr_err pulses.
  - Third byte starts the frame; the final frame has frame_target=0.
- Backpressure: frame_ready=0 for 20 cycles after frame_valid:
  - s_ready=0 throughout and outputs stable.
  - frame_valid falls on the cycle after frame_ready=1 is sampled, and s_ready returns to 1 at the same time.
- Random s_valid gaps (about 50% duty) over a full frame with target 4 and ctrl 0x21:
  - frame_data is bit-identical to the gap-free reference.
  - frame_target=4, prio=2, emer=1.
- Reset pulse after payload byte 100, then a clean frame (target 1, ctrl 0x80):
  - No frame_valid for the aborted frame.
  - Clean frame gives frame_target=1, prio=8, emer=0, with correct data.
- Five consecutive frames targeting 0..4 with distinct prio/emer:
  - Exactly five frame_valid handshakes, in order, each with matching tags.

Source files
------------

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared traffic-signal constants, frame geometry and loader state type
package traffic_pkg;

  localparam int SIG_MID = 0;
  localparam int SIG_L   = 1;
  localparam int SIG_R   = 2;
  localparam int SIG_T   = 3;
  localparam int SIG_D   = 4;
  localparam int N_SIG   = 5;

  localparam int BYTE_W      = 8;
  localparam int FRAME_BITS  = 3072;
  localparam int FRAME_BYTES = FRAME_BITS / BYTE_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CTRL    = 2'd2,
    HOLD    = 2'd3
  } loader_state_t;

endpackage

// File: rtl/img_frame_loader_if.sv
// rtl/img_frame_loader_if.sv - byte-stream input and assembled-frame output bundle for the frame loader
interface img_frame_loader_if #(
  parameter int FRAME_BITS = traffic_pkg::FRAME_BITS,
  parameter int BYTE_W     = traffic_pkg::BYTE_W
);

  logic                  s_valid;
  logic                  s_ready;
  logic [BYTE_W-1:0]     s_data;
  logic                  frame_valid;
  logic                  frame_ready;
  logic [FRAME_BITS-1:0] frame_data;
  logic [2:0]            frame_target;
  logic [3:0]            frame_prio;
  logic [3:0]            frame_emer;
  logic                  hdr_err;

  // slave is the loader; master is whatever feeds bytes and consumes frames
  modport slave (
    input  s_valid, s_data, frame_ready,
    output s_ready, frame_valid, frame_data, frame_target, frame_prio, frame_emer, hdr_err
  );

  modport master (
    output s_valid, s_data, frame_ready,
    input  s_ready, frame_valid, frame_data, frame_target, frame_prio, frame_emer, hdr_err
  );

endinterface

// File: rtl/img_frame_loader.sv
// rtl/img_frame_loader.sv - assembles header/payload/control byte stream into one tagged 3072-bit frame
module img_frame_loader #(
  parameter int FRAME_BITS = traffic_pkg::FRAME_BITS,
  parameter int BYTE_W     = traffic_pkg::BYTE_W,
  parameter int N_SIG      = traffic_pkg::N_SIG
) (
  input  logic                clk,
  input  logic                rst_n,
  img_frame_loader_if.slave   bus
);

  import traffic_pkg::*;

  localparam int PAYLOAD_BYTES = FRAME_BITS / BYTE_W;
  localparam int CNT_W         = $clog2(PAYLOAD_BYTES + 1);
  localparam int IDX_W         = $clog2(FRAME_BITS);

  loader_state_t         state;
  loader_state_t         nextState;
  logic [CNT_W-1:0]      byteCnt;
  logic [FRAME_BITS-1:0] frameData;
  logic [2:0]            frameTarget;
  logic [3:0]            framePrio;
  logic [3:0]            frameEmer;
  logic                  hdrErr;

  logic                  byteTake;
  logic                  hdrOk;
  logic                  lastPayload;
  logic [IDX_W-1:0]      byteBase;

  // Ready/valid come straight from the state register so neither side sees a combinational loop.
  assign bus.s_ready     = (state != HOLD);
  assign bus.frame_valid = (state == HOLD);

  assign byteTake    = bus.s_valid && bus.s_ready;
  assign hdrOk       = (bus.s_data[BYTE_W-1:3] == '0) && (int'(bus.s_data[2:0]) < N_SIG);
  assign lastPayload = (byteCnt == CNT_W'(PAYLOAD_BYTES - 1));
  // First payload byte lands in the top byte lane, matching the text order of the frame files.
  assign byteBase    = IDX_W'(FRAME_BITS - 1) - IDX_W'(BYTE_W) * IDX_W'(byteCnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (byteTake && hdrOk)       nextState = PAYLOAD;
      PAYLOAD: if (byteTake && lastPayload) nextState = CTRL;
      CTRL:    if (byteTake)                nextState = HOLD;
      HOLD:    if (bus.frame_ready)         nextState = IDLE;
      default:                              nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byteCnt     <= '0;
      frameData   <= '0;
      frameTarget <= '0;
      framePrio   <= '0;
      frameEmer   <= '0;
      hdrErr      <= 1'b0;
    end else begin
      hdrErr <= byteTake && (state == IDLE) && !hdrOk;
      case (state)
        IDLE: begin
          if (byteTake && hdrOk) begin
            frameTarget <= bus.s_data[2:0];
            byteCnt     <= '0;
          end
        end
        PAYLOAD: begin
          if (byteTake) begin
            frameData[byteBase -: BYTE_W] <= bus.s_data;
            byteCnt                       <= byteCnt + 1'b1;
          end
        end
        CTRL: begin
          if (byteTake) begin
            framePrio <= bus.s_data[7:4];
            frameEmer <= bus.s_data[3:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.frame_data   = frameData;
  assign bus.frame_target = frameTarget;
  assign bus.frame_prio   = framePrio;
  assign bus.frame_emer   = frameEmer;
  assign bus.hdr_err      = hdrErr;

endmodule

// File: tb/tb_img_frame_loader.sv
// tb/tb_img_frame_loader.sv - directed self-checking bench for img_frame_loader
module tb_img_frame_loader;

  import traffic_pkg::*;

  localparam int FB = FRAME_BITS;
  localparam int NB = FRAME_BYTES;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  img_frame_loader_if bus ();

  img_frame_loader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int nCompared   = 0;
  int nMismatched = 0;
  int hsCount     = 0;
  int errCount    = 0;
  logic [2:0] hsTargets[$];

  always @(posedge clk) begin
    if (rst_n && bus.frame_valid && bus.frame_ready) begin
      hsCount++;
      hsTargets.push_back(bus.frame_target);
    end
    if (rst_n && bus.hdr_err) errCount++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, compared %0d", nCompared);
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] pat(input int id, input int k);
    case (id)
      0:       return 8'(k & 255);
      1:       return 8'((k * 7 + 3) & 255);
      2:       return 8'((k * 13 + 5) & 255);
      3:       return 8'((k ^ 165) & 255);
      default: return 8'((k * 3 + id) & 255);
    endcase
  endfunction

  function automatic logic [FB-1:0] buildRef(input int id);
    logic [FB-1:0] r;
    r = '0;
    for (int k = 0; k < NB; k++) r = {r[FB-9:0], pat(id, k)};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chkData(input string tag, input logic [FB-1:0] exp);
    logic [FB-1:0] a;
    logic [FB-1:0] e;
    int first;
    logic [7:0] ob;
    logic [7:0] eb;
    nCompared++;
    assert (bus.frame_data === exp) else begin
      nMismatched++;
      a = bus.frame_data;
      e = exp;
      first = -1;
      ob = 8'h00;
      eb = 8'h00;
      for (int k = 0; k < NB; k++) begin
        if (first < 0 && a[FB-1 -: 8] !== e[FB-1 -: 8]) begin
          first = k;
          ob = a[FB-1 -: 8];
          eb = e[FB-1 -: 8];
        end
        a = a << 8;
        e = e << 8;
      end
      $error("FAIL %s: payload byte %0d observed 0x%0h expected 0x%0h", tag, first, ob, eb);
    end
  endtask

  task automatic sendByte(input logic [7:0] b, input bit gaps);
    int n;
    if (gaps) begin
      bus.s_valid = 1'b0;
      repeat ($urandom_range(0, 1)) begin
        @(posedge clk);
        #1;
      end
    end
    bus.s_data  = b;
    bus.s_valid = 1'b1;
    n = 0;
    while (!bus.s_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.s_ready) chk("s_ready_timeout", 32'(bus.s_ready), 1);
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
  endtask

  task automatic sendBody(input int id, input logic [7:0] ctrl, input bit gaps, output logic fvPre);
    for (int k = 0; k < NB; k++) sendByte(pat(id, k), gaps);
    fvPre = bus.frame_valid;
    sendByte(ctrl, gaps);
  endtask

  task automatic sendFrame(input logic [7:0] hdr, input int id, input logic [7:0] ctrl,
                           input bit gaps, output logic fvPre);
    sendByte(hdr, gaps);
    sendBody(id, ctrl, gaps, fvPre);
  endtask

  initial begin
    logic          fvPre;
    logic [FB-1:0] snap;
    logic [FB-1:0] dataT1;
    int            bad;
    int            hs0;
    int            err0;

    bus.s_valid     = 1'b0;
    bus.s_data      = 8'h00;
    bus.frame_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    chk("rst_s_ready", 32'(bus.s_ready), 1);
    chk("rst_frame_valid", 32'(bus.frame_valid), 0);
    chk("rst_hdr_err", 32'(bus.hdr_err), 0);
    chk("rst_target", 32'(bus.frame_target), 0);
    chk("rst_prio", 32'(bus.frame_prio), 0);
    chk("rst_emer", 32'(bus.frame_emer), 0);
    chk("rst_data_nonzero", 32'(|bus.frame_data), 0);
    rst_n = 1'b1;

    // back-to-back frame, header 0x02, ctrl 0x48
    bus.frame_ready = 1'b1;
    sendFrame(8'h02, 0, 8'h48, 1'b0, fvPre);
    chk("t1_fv_before_ctrl", 32'(fvPre), 0);
    chk("t1_fv_after_ctrl", 32'(bus.frame_valid), 1);
    chk("t1_s_ready_hold", 32'(bus.s_ready), 0);
    chk("t1_target", 32'(bus.frame_target), 2);
    chk("t1_prio", 32'(bus.frame_prio), 4);
    chk("t1_emer", 32'(bus.frame_emer), 8);
    dataT1 = bus.frame_data;
    chk("t1_msb_byte", 32'(dataT1[3071:3064]), 32'h00);
    chk("t1_lsb_byte", 32'(dataT1[7:0]), 32'h7F);
    chkData("t1_data", buildRef(0));
    @(posedge clk);
    #1;
    chk("t1_fv_one_cycle", 32'(bus.frame_valid), 0);
    chk("t1_s_ready_back", 32'(bus.s_ready), 1);
    chk("t1_hs_count", 32'(hsCount), 1);

    // bad headers 0x05, 0x0B then valid 0x00
    err0 = errCount;
    sendByte(8'h05, 1'b0);
    chk("t2_err_pulse1", 32'(bus.hdr_err), 1);
    chk("t2_idle_after_bad", 32'(bus.s_ready), 1);
    sendByte(8'h0B, 1'b0);
    chk("t2_err_pulse2", 32'(bus.hdr_err), 1);
    sendByte(8'h00, 1'b0);
    chk("t2_no_err_good_hdr", 32'(bus.hdr_err), 0);
    sendBody(1, 8'h3C, 1'b0, fvPre);
    chk("t2_err_count", 32'(errCount - err0), 2);
    chk("t2_fv", 32'(bus.frame_valid), 1);
    chk("t2_target", 32'(bus.frame_target), 0);
    chk("t2_prio", 32'(bus.frame_prio), 3);
    chk("t2_emer", 32'(bus.frame_emer), 12);
    chkData("t2_data", buildRef(1));
    @(posedge clk);
    #1;

    // backpressure: frame_ready low for 20 cycles, with a byte offered during HOLD
    bus.frame_ready = 1'b0;
    sendFrame(8'h03, 3, 8'h5A, 1'b0, fvPre);
    snap = bus.frame_data;
    bad = 0;
    bus.s_data  = 8'hFF;
    bus.s_valid = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.s_ready !== 1'b0 || bus.frame_valid !== 1'b1 || bus.frame_data !== snap ||
          bus.frame_target !== 3'd3 || bus.frame_prio !== 4'd5 || bus.frame_emer !== 4'hA)
        bad++;
    end
    bus.s_valid = 1'b0;
    chk("t3_hold_stable", 32'(bad), 0);
    chkData("t3_data", buildRef(3));
    chk("t3_target", 32'(bus.frame_target), 3);
    chk("t3_prio", 32'(bus.frame_prio), 5);
    chk("t3_emer", 32'(bus.frame_emer), 10);
    bus.frame_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("t3_fv_fall", 32'(bus.frame_valid), 0);
    chk("t3_s_ready_rise", 32'(bus.s_ready), 1);

    // random s_valid gaps, target 4, ctrl 0x21
    sendFrame(8'h04, 2, 8'h21, 1'b1, fvPre);
    chk("t4_fv", 32'(bus.frame_valid), 1);
    chkData("t4_data", buildRef(2));
    chk("t4_target", 32'(bus.frame_target), 4);
    chk("t4_prio", 32'(bus.frame_prio), 2);
    chk("t4_emer", 32'(bus.frame_emer), 1);
    @(posedge clk);
    #1;

    // reset after payload byte 100, then a clean frame
    hs0 = hsCount;
    sendByte(8'h01, 1'b0);
    for (int k = 0; k <= 100; k++) sendByte(pat(3, k), 1'b0);
    rst_n = 1'b0;
    #2;
    chk("t5_rst_fv", 32'(bus.frame_valid), 0);
    chk("t5_rst_s_ready", 32'(bus.s_ready), 1);
    chk("t5_rst_target", 32'(bus.frame_target), 0);
    chk("t5_rst_data_nonzero", 32'(|bus.frame_data), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sendFrame(8'h01, 4, 8'h80, 1'b0, fvPre);
    chk("t5_no_aborted_hs", 32'(hsCount - hs0), 0);
    chk("t5_fv", 32'(bus.frame_valid), 1);
    chk("t5_target", 32'(bus.frame_target), 1);
    chk("t5_prio", 32'(bus.frame_prio), 8);
    chk("t5_emer", 32'(bus.frame_emer), 0);
    chkData("t5_data", buildRef(4));
    @(posedge clk);
    #1;

    // five consecutive frames to targets 0..4
    hs0 = hsCount;
    hsTargets.delete();
    for (int t = 0; t < 5; t++) begin
      sendFrame(8'(t), t, {4'(t + 1), 4'(9 - t)}, 1'b0, fvPre);
      chk($sformatf("t6_target%0d", t), 32'(bus.frame_target), 32'(t));
      chk($sformatf("t6_prio%0d", t), 32'(bus.frame_prio), 32'(t + 1));
      chk($sformatf("t6_emer%0d", t), 32'(bus.frame_emer), 32'(9 - t));
    end
    @(posedge clk);
    #1;
    chk("t6_hs_count", 32'(hsCount - hs0), 5);
    if (hsTargets.size() == 5) begin
      for (int i = 0; i < 5; i++) chk($sformatf("t6_hs_order%0d", i), 32'(hsTargets[i]), 32'(i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
